// File: rtl/stp_rx_pkg.sv
// Shared types and sizing helpers for the serial receive controller.
package stp_rx_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_CHK = 3'd1,
        RECV      = 3'd2,
        STOP_CHK  = 3'd3,
        LOAD      = 3'd4
    } rx_state_t;

    // Wide enough to count payload, optional parity and stop shifts.
    function automatic int bit_cnt_width(input int data_bits);
        return $clog2(data_bits + 3);
    endfunction

endpackage

// File: rtl/flex_stp_sr.sv
// Flexible serial-to-parallel shift register; resets to all ones (line idle level).
module flex_stp_sr #(
    parameter int NUM_BITS  = 4,
    parameter bit SHIFT_MSB = 1'b1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                shift_enable,
    input  logic                serial_in,
    output logic [NUM_BITS-1:0] parallel_out
);

    logic [NUM_BITS-1:0] sr_q;
    logic [NUM_BITS-1:0] sr_d;

    // SHIFT_MSB=0 enters at the MSB so the first bit received ends up in bit 0.
    always_comb begin
        sr_d = sr_q;
        if (shift_enable) begin
            if (SHIFT_MSB) begin
                sr_d = {sr_q[NUM_BITS-2:0], serial_in};
            end else begin
                sr_d = {serial_in, sr_q[NUM_BITS-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sr_q <= '1;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign parallel_out = sr_q;

endmodule

// File: rtl/stp_rx_bit_timer.sv
// Bit-period counter; sample_tick marks the mid-bit sample point of every bit period.
module rx_bit_timer #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    output logic sample_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sample_tick = enable && (cnt_q == HALF_CNT);

endmodule

// File: rtl/stp_rx_controller.sv
// Serial receive controller: sync, start/stop validation, word hand-off with status.
// Optional even-parity frame bit and parity_error port when STP_RX_PARITY_EN is defined.
module stp_rx_controller
    import stp_rx_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 10
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 serial_in,
    input  logic                 data_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 framing_error,
    output logic                 overrun_error,
    output logic                 busy
`ifdef STP_RX_PARITY_EN
    ,
    output logic                 parity_error
`endif
);

`ifdef STP_RX_PARITY_EN
    localparam int NUM_BITS = DATA_BITS + 2;
`else
    localparam int NUM_BITS = DATA_BITS + 1;
`endif
    localparam int STOP_IDX = NUM_BITS - 1;
    localparam int CW       = bit_cnt_width(DATA_BITS);
    localparam logic [CW-1:0] LAST_SHIFT = CW'(NUM_BITS - 1);

    rx_state_t state_q, state_d;

    logic sync1_q, sync2_q, prev_q;
    logic start_edge;
    logic sample_tick, timer_clear, timer_en, shift_enable;
    logic [NUM_BITS-1:0] sr;

    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 data_ready_q, data_ready_d;
    logic                 fe_q, fe_d;
    logic                 oe_q, oe_d;
`ifdef STP_RX_PARITY_EN
    logic                 pe_q, pe_d;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= serial_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign start_edge = prev_q && !sync2_q;

    rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk        (clk),
        .n_rst      (n_rst),
        .clear      (timer_clear),
        .enable     (timer_en),
        .sample_tick(sample_tick)
    );

    flex_stp_sr #(.NUM_BITS(NUM_BITS), .SHIFT_MSB(1'b0)) u_sr (
        .clk         (clk),
        .n_rst       (n_rst),
        .shift_enable(shift_enable),
        .serial_in   (sync2_q),
        .parallel_out(sr)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start_edge) state_d = START_CHK;
            START_CHK: if (sample_tick) state_d = sync2_q ? IDLE : RECV;
            RECV:      if (sample_tick && (bit_cnt_q == LAST_SHIFT)) state_d = STOP_CHK;
            STOP_CHK:  state_d = sr[STOP_IDX] ? LOAD : IDLE;
            LOAD:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q != IDLE);
        timer_clear  = (state_q == IDLE) && start_edge;
        timer_en     = (state_q == START_CHK) || (state_q == RECV);
        shift_enable = (state_q == RECV) && sample_tick;
    end

    // data_ready/data_read: a word is offered while data_ready is high; the
    // consumer takes it with a one-cycle data_read, which frees the holding
    // register on the next clock. data_read while data_ready is low is ignored.
    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        rx_data_d    = rx_data_q;
        data_ready_d = data_ready_q;
        fe_d         = fe_q;
        oe_d         = oe_q;
`ifdef STP_RX_PARITY_EN
        pe_d         = pe_q;
`endif
        if (data_read && data_ready_q) begin
            data_ready_d = 1'b0;
            oe_d         = 1'b0;
        end
        case (state_q)
            START_CHK: begin
                if (sample_tick && !sync2_q) begin
                    fe_d      = 1'b0;
                    bit_cnt_d = '0;
`ifdef STP_RX_PARITY_EN
                    pe_d      = 1'b0;
`endif
                end
            end
            RECV:     if (sample_tick) bit_cnt_d = bit_cnt_q + 1'b1;
            STOP_CHK: if (!sr[STOP_IDX]) fe_d = 1'b1;
            LOAD: begin
                rx_data_d    = sr[DATA_BITS-1:0];
                data_ready_d = 1'b1;
                // A same-cycle read consumes the old word, so no overrun.
                if (data_ready_q && !data_read) oe_d = 1'b1;
`ifdef STP_RX_PARITY_EN
                pe_d         = ^sr[DATA_BITS:0];
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_cnt_q    <= '0;
            rx_data_q    <= '1;
            data_ready_q <= 1'b0;
            fe_q         <= 1'b0;
            oe_q         <= 1'b0;
`ifdef STP_RX_PARITY_EN
            pe_q         <= 1'b0;
`endif
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            rx_data_q    <= rx_data_d;
            data_ready_q <= data_ready_d;
            fe_q         <= fe_d;
            oe_q         <= oe_d;
`ifdef STP_RX_PARITY_EN
            pe_q         <= pe_d;
`endif
        end
    end

    assign rx_data       = rx_data_q;
    assign data_ready    = data_ready_q;
    assign framing_error = fe_q;
    assign overrun_error = oe_q;
`ifdef STP_RX_PARITY_EN
    assign parity_error  = pe_q;
`endif

endmodule

// File: tb/tb_stp_rx_controller.sv
// Directed bench for stp_rx_controller: frames are queued with expected status
// and checked by a monitor each time the controller returns to idle.
module tb_stp_rx_controller;

  localparam int DB  = 8;
  localparam int CPB = 10;
`ifdef STP_RX_PARITY_EN
  localparam int NSH = DB + 2;
`else
  localparam int NSH = DB + 1;
`endif
  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_rst;
  logic serial_in;
  logic data_read;
  logic [DB-1:0] rx_data;
  logic data_ready, framing_error, overrun_error, busy;
`ifdef STP_RX_PARITY_EN
  logic parity_error;
`endif

  always #5 clk = ~clk;

  stp_rx_controller #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .serial_in    (serial_in),
    .data_read    (data_read),
    .rx_data      (rx_data),
    .data_ready   (data_ready),
    .framing_error(framing_error),
    .overrun_error(overrun_error),
    .busy         (busy)
`ifdef STP_RX_PARITY_EN
    ,
    .parity_error (parity_error)
`endif
  );

  // ---------------- scoreboard state ----------------
  // record: [15] parity_error, [14:7] rx_data, [6] ready, [5] framing, [4] overrun, [3:0] shift pulses
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic mon_skip = 1'b0;

  logic [DB-1:0] m_data = '1;
  logic m_ready = 1'b0, m_fe = 1'b0, m_oe = 1'b0, m_pe = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] mk_rec(input logic [3:0] pulses);
    return {m_pe, m_data, m_ready, m_fe, m_oe, pulses};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic rd_at_load,
                            input logic par);
    m_fe = 1'b0;
    m_pe = 1'b0;
    if (!stop) begin
      m_fe = 1'b1;
    end else begin
      if (rd_at_load) m_oe = 1'b0;
      else if (m_ready) m_oe = 1'b1;
      m_ready = 1'b1;
      m_data  = d;
`ifdef STP_RX_PARITY_EN
      m_pe = ^{d, par};
`endif
    end
    exp_q.push_back(mk_rec(4'(NSH)));
    @(negedge clk) serial_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      serial_in = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef STP_RX_PARITY_EN
    serial_in = par;
    repeat (CPB) @(negedge clk);
`else
    serial_in = par & 1'b0 | serial_in;
`endif
    serial_in = stop;
    if (rd_at_load) begin
      repeat (CPB - 1) @(negedge clk);
      data_read = 1'b1;
      @(negedge clk);
      data_read = 1'b0;
    end else begin
      repeat (CPB) @(negedge clk);
    end
    serial_in = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic glitch(input int len);
    exp_q.push_back(mk_rec(4'd0));
    @(negedge clk) serial_in = 1'b0;
    repeat (len) @(negedge clk);
    serial_in = 1'b1;
    repeat (15) @(negedge clk);
  endtask

  task automatic read_word();
    @(negedge clk) data_read = 1'b1;
    @(negedge clk) data_read = 1'b0;
    if (m_ready) begin
      m_ready = 1'b0;
      m_oe    = 1'b0;
    end
    check("read_ready", data_ready, m_ready);
    check("read_overrun", overrun_error, m_oe);
  endtask

  task automatic reset_mid_frame(input logic [DB-1:0] d);
    mon_skip = 1'b1;
    @(negedge clk) serial_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      serial_in = d[i];
      repeat (CPB) @(negedge clk);
    end
    serial_in = d[4];
    repeat (5) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("rst_rx_data", rx_data, {DB{1'b1}});
    check("rst_ready", data_ready, 1'b0);
    check("rst_framing", framing_error, 1'b0);
    check("rst_overrun", overrun_error, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk) serial_in = 1'b1;
    #2 n_rst = 1'b1;
    m_data = '1; m_ready = 1'b0; m_fe = 1'b0; m_oe = 1'b0; m_pe = 1'b0;
    repeat (20) @(negedge clk);
    mon_skip = 1'b0;
  endtask

  // ---------------- monitor ----------------
  logic busy_prev = 1'b0;
  int pulse_cnt = 0;
  int last_pulse = -1;

  always @(negedge clk) begin
    logic [W-1:0] rec;
    cyc++;
    if (mon_skip) begin
      busy_prev  = 1'b0;
      pulse_cnt  = 0;
      last_pulse = -1;
    end else begin
      if (dut.shift_enable) begin
        if (last_pulse >= 0) check("shift_gap", cyc - last_pulse, CPB);
        last_pulse = cyc;
        pulse_cnt++;
      end
      if (busy_prev && !busy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_idle", 1, 0);
        end else begin
          rec = exp_q.pop_front();
          check("rx_data", rx_data, rec[14:7]);
          check("data_ready", data_ready, rec[6]);
          check("framing_error", framing_error, rec[5]);
          check("overrun_error", overrun_error, rec[4]);
          check("shift_pulses", pulse_cnt, rec[3:0]);
`ifdef STP_RX_PARITY_EN
          check("parity_error", parity_error, rec[15]);
`endif
        end
        pulse_cnt  = 0;
        last_pulse = -1;
      end
      busy_prev = busy;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    n_rst     = 1'b0;
    serial_in = 1'b1;
    data_read = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("init_rx_data", rx_data, 8'hFF);
    check("init_ready", data_ready, 1'b0);
    check("init_framing", framing_error, 1'b0);
    check("init_overrun", overrun_error, 1'b0);
    check("init_busy", busy, 1'b0);
    n_rst = 1'b1;
    repeat (5) @(negedge clk);

    glitch(3);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    read_word();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    read_word();
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
    read_word();
    send_frame(8'h11, 1'b1, 1'b0, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1, 1'b0);
    read_word();
    reset_mid_frame(8'h81);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    read_word();
`ifdef STP_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    read_word();
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    read_word();
`endif

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
